// File: rtl/rtlola_seq_pkg.sv
// Shared types and width helpers for the RTLola event sequencer.
package rtlola_seq_pkg;

  typedef enum logic {StIdle = 1'b0, StEval = 1'b1} seq_state_e;

  // Queue entry layout, MSB to LSB: {data, new mask, periodic tick, timestamp}
  function automatic int unsigned entry_width(input int unsigned n_in, input int unsigned dw,
                                              input int unsigned tsw);
    return n_in * dw + n_in + 1 + tsw;
  endfunction

  // Width of a stage index; never narrower than one bit
  function automatic int unsigned stage_width(input int unsigned n_stages);
    return (n_stages > 1) ? $clog2(n_stages) : 1;
  endfunction

endpackage

// File: rtl/rtlola_event_fifo.sv
// DEPTH x WIDTH synchronous FIFO with extra-bit pointers for full/empty.
// A pop and a push in the same cycle both succeed, also when full.
module rtlola_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  // A full queue still accepts a push when the head leaves in the same cycle
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PtrOne;
      if (w_do_pop)  r_rptr <= r_rptr + PtrOne;
    end
  end

  // Storage write; contents are don't-care until written
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/rtlola_event_sequencer.sv
// Front-end controller for compiled RTLola monitors: timestamps and queues
// sporadic events and periodic ticks, then replays each one as an HLC pulse
// plus an N_STAGES-long LLC stage sequence.
// Optional: define RTLOLA_DROP_CNT_EN to add the saturating o_drop_cnt output.
module rtlola_event_sequencer
  import rtlola_seq_pkg::*;
#(
  parameter int unsigned N_IN     = 3,
  parameter int unsigned DW       = 8,
  parameter int unsigned N_STAGES = 5,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PERIOD   = 250,
  parameter int unsigned TSW      = 64,
  localparam int unsigned SW      = stage_width(N_STAGES)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic [N_IN*DW-1:0]   i_in_data,
  input  logic [N_IN-1:0]      i_in_new,
  output logic                 o_hlc_clock,
  output logic [TSW-1:0]       o_hlc_clock_cnt,
  output logic [N_IN*DW-1:0]   o_ev_data,
  output logic [N_IN-1:0]      o_ev_new,
  output logic                 o_ev_periodic,
  output logic [SW-1:0]        o_llc_stage,
  output logic                 o_stage_valid,
  output logic                 o_busy,
`ifdef RTLOLA_DROP_CNT_EN
  output logic [15:0]          o_drop_cnt,
`endif
  output logic                 o_overflow
);

  localparam int unsigned EW        = entry_width(N_IN, DW, TSW);
  localparam logic [SW-1:0] LastStage = SW'(N_STAGES - 1);

  logic [TSW-1:0]     r_ts;
  logic               w_tick;
  logic               w_capture;
  logic               w_pop;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [EW-1:0]      w_wentry;
  logic [EW-1:0]      w_rentry;
  seq_state_e         r_state;
  seq_state_e         w_state_nxt;
  logic [SW-1:0]      r_stage;
  logic [SW-1:0]      w_stage_nxt;
  logic [TSW-1:0]     r_ev_ts;
  logic [N_IN*DW-1:0] r_ev_data;
  logic [N_IN-1:0]    r_ev_new;
  logic               r_ev_periodic;
  logic               r_overflow;

  // Timestamp: free-running while enabled, wraps naturally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_ts <= '0;
    else if (i_en) r_ts <= r_ts + TSW'(1);
  end

  if (PERIOD > 0) begin : g_period
    localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] PerLast = PW'(PERIOD - 1);
    logic [PW-1:0] r_per;

    // Periodic counter 0..PERIOD-1; tick is the cycle it sits at the top value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  r_per <= '0;
      else if (i_en) r_per <= (r_per == PerLast) ? '0 : r_per + PW'(1);
    end

    assign w_tick = (r_per == PerLast);
  end else begin : g_no_period
    assign w_tick = 1'b0;
  end

  // A sporadic event and a tick in the same cycle share one entry
  assign w_capture = i_en & ((|i_in_new) | w_tick);
  assign w_wentry  = {i_in_data, i_in_new, w_tick, r_ts};
  assign w_pop     = ~w_empty & ((r_state == StIdle) |
                                 ((r_state == StEval) & (r_stage == LastStage)));
  assign w_drop    = w_capture & w_full & ~w_pop;

  rtlola_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_capture),
    .i_wdata (w_wentry),
    .i_pop   (w_pop),
    .o_rdata (w_rentry),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sequencer state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_stage <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
    end
  end

  // Sequencer next state: last stage chains straight into the next queued event
  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_state_nxt = StEval;
          w_stage_nxt = '0;
        end
      end
      StEval: begin
        if (r_stage == LastStage) begin
          w_stage_nxt = '0;
          w_state_nxt = w_empty ? StIdle : StEval;
        end else begin
          w_stage_nxt = r_stage + SW'(1);
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_stage_nxt = '0;
      end
    endcase
  end

  // Sequencer outputs
  always_comb begin
    o_stage_valid = (r_state == StEval);
    o_llc_stage   = r_stage;
    o_hlc_clock   = (r_state == StEval) && (r_stage == '0);
    o_busy        = (r_state == StEval) | ~w_empty;
  end

  // Event latch: loaded from the queue head on every pop, held for the whole sequence
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ev_ts       <= '0;
      r_ev_data     <= '0;
      r_ev_new      <= '0;
      r_ev_periodic <= 1'b0;
    end else if (w_pop) begin
      r_ev_ts       <= w_rentry[TSW-1:0];
      r_ev_periodic <= w_rentry[TSW];
      r_ev_new      <= w_rentry[TSW+1 +: N_IN];
      r_ev_data     <= w_rentry[TSW+1+N_IN +: N_IN*DW];
    end
  end

  // Sticky drop flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

`ifdef RTLOLA_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  // Saturating drop counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                 r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign o_drop_cnt = r_drop_cnt;
`endif

  assign o_hlc_clock_cnt = r_ev_ts;
  assign o_ev_data       = r_ev_data;
  assign o_ev_new        = r_ev_new;
  assign o_ev_periodic   = r_ev_periodic;
  assign o_overflow      = r_overflow;

endmodule
